// File: rtl/ysyx_24100006_wbu_pkg.sv
// Shared definitions for the write-back unit.
// Holds the GPR/CSR data-select encodings, the trap CSR addresses and the
// FSM state encoding. Imported by the interface-using top module.
package ysyx_24100006_wbu_pkg;

  localparam logic [11:0] MepcAddr   = 12'h341;
  localparam logic [11:0] McauseAddr = 12'h342;

  // GPR write-back data select; codes 5-7 are unused and yield zero.
  typedef enum logic [2:0] {
    GprSelAlu = 3'd0,
    GprSelImm = 3'd1,
    GprSelMem = 3'd2,
    GprSelPc4 = 3'd3,
    GprSelCsr = 3'd4
  } gpr_sel_e;

  // CSR write-back data select (csrrw / csrrs / csrrc / ALU-computed).
  typedef enum logic [1:0] {
    CsrSelRw  = 2'd0,
    CsrSelRs  = 2'd1,
    CsrSelRc  = 2'd2,
    CsrSelAlu = 2'd3
  } csr_sel_e;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StTrapCause = 2'd1,
    StHalt      = 2'd2
  } wbu_state_e;

endpackage

// File: rtl/ysyx_24100006_wbu_if.sv
// MEM/WB to WBU bus: valid/ready handshake plus the retired-instruction payload.
//   master : the MEM/WB pipeline register (drives in_valid and payload)
//   slave  : the write-back unit (drives in_ready)
interface ysyx_24100006_wbu_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_i;
  logic [31:0] alu_result_i;
  logic [31:0] sext_imm_i;
  logic [31:0] Mem_rdata_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rdata_csr_i;
  logic [3:0]  Gpr_Write_Addr_i;
  logic [11:0] Csr_Write_Addr_i;
  logic [2:0]  Gpr_Write_RD_i;
  logic [1:0]  Csr_Write_RD_i;
  logic [7:0]  irq_no_i;
  logic        irq_i;
  logic        Gpr_Write_i;
  logic        Csr_Write_i;
  logic        is_break_i;

  modport master (
    output in_valid, pc_i, alu_result_i, sext_imm_i, Mem_rdata_i, rs1_data_i, rdata_csr_i,
           Gpr_Write_Addr_i, Csr_Write_Addr_i, Gpr_Write_RD_i, Csr_Write_RD_i, irq_no_i,
           irq_i, Gpr_Write_i, Csr_Write_i, is_break_i,
    input  in_ready
  );

  modport slave (
    input  in_valid, pc_i, alu_result_i, sext_imm_i, Mem_rdata_i, rs1_data_i, rdata_csr_i,
           Gpr_Write_Addr_i, Csr_Write_Addr_i, Gpr_Write_RD_i, Csr_Write_RD_i, irq_no_i,
           irq_i, Gpr_Write_i, Csr_Write_i, is_break_i,
    output in_ready
  );

endinterface

// File: rtl/ysyx_24100006_wbu.sv
// Write-back unit: consumer end of the MEM/WB handshake.
// Accepts one retired instruction per handshake, selects GPR/CSR write data and
// emits registered single-cycle write strobes. Trap entry writes mepc then
// mcause on two consecutive cycles; ebreak halts the unit until reset.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   bus            MEM/WB handshake + payload (slave side)
//   gpr_we/waddr/wdata   register-file write port
//   csr_we/waddr/wdata   CSR-file write port
//   commit_valid/pc      retire pulse and PC for difftest
//   break_o              ebreak retire pulse
module ysyx_24100006_wbu
  import ysyx_24100006_wbu_pkg::*;
#(
  parameter logic [11:0] MEPC_ADDR   = MepcAddr,
  parameter logic [11:0] MCAUSE_ADDR = McauseAddr
) (
  input  logic                 clk,
  input  logic                 reset,
  ysyx_24100006_wbu_if.slave   bus,
  output logic                 gpr_we,
  output logic [3:0]           gpr_waddr,
  output logic [31:0]          gpr_wdata,
  output logic                 csr_we,
  output logic [11:0]          csr_waddr,
  output logic [31:0]          csr_wdata,
  output logic                 commit_valid,
  output logic [31:0]          commit_pc,
  output logic                 break_o
);

  wbu_state_e state_q, state_d;

  logic        gpr_we_q, gpr_we_d;
  logic [3:0]  gpr_waddr_q, gpr_waddr_d;
  logic [31:0] gpr_wdata_q, gpr_wdata_d;
  logic        csr_we_q, csr_we_d;
  logic [11:0] csr_waddr_q, csr_waddr_d;
  logic [31:0] csr_wdata_q, csr_wdata_d;
  logic        commit_valid_q, commit_valid_d;
  logic [31:0] commit_pc_q, commit_pc_d;
  logic        break_q, break_d;
  logic [7:0]  irq_no_q, irq_no_d;
  logic [31:0] trap_pc_q, trap_pc_d;

  logic        accept;
  logic        take_trap;
  logic [31:0] gpr_sel_data;
  logic [31:0] csr_sel_data;

  // Ready depends on state only so the producer never sees a comb loop.
  assign bus.in_ready = (state_q == StIdle);
  assign accept       = bus.in_valid && bus.in_ready;
  // ebreak wins over a simultaneous trap request.
  assign take_trap    = accept && bus.irq_i && !bus.is_break_i;

  always_comb begin
    gpr_sel_data = 32'b0;
    case (gpr_sel_e'(bus.Gpr_Write_RD_i))
      GprSelAlu: gpr_sel_data = bus.alu_result_i;
      GprSelImm: gpr_sel_data = bus.sext_imm_i;
      GprSelMem: gpr_sel_data = bus.Mem_rdata_i;
      GprSelPc4: gpr_sel_data = bus.pc_i + 32'd4;
      GprSelCsr: gpr_sel_data = bus.rdata_csr_i;
      default:   gpr_sel_data = 32'b0;
    endcase
  end

  always_comb begin
    csr_sel_data = 32'b0;
    unique case (csr_sel_e'(bus.Csr_Write_RD_i))
      CsrSelRw:  csr_sel_data = bus.rs1_data_i;
      CsrSelRs:  csr_sel_data = bus.rdata_csr_i | bus.rs1_data_i;
      CsrSelRc:  csr_sel_data = bus.rdata_csr_i & ~bus.rs1_data_i;
      CsrSelAlu: csr_sel_data = bus.alu_result_i;
      default:   csr_sel_data = 32'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && bus.is_break_i) begin
          state_d = StHalt;
        end else if (take_trap) begin
          state_d = StTrapCause;
        end
      end
      StTrapCause: state_d = StIdle;
      StHalt:      state_d = StHalt;
      default:     state_d = StIdle;
    endcase
  end

  // Output next-state logic: strobes default low, addr/data hold.
  always_comb begin
    gpr_we_d       = 1'b0;
    gpr_waddr_d    = gpr_waddr_q;
    gpr_wdata_d    = gpr_wdata_q;
    csr_we_d       = 1'b0;
    csr_waddr_d    = csr_waddr_q;
    csr_wdata_d    = csr_wdata_q;
    commit_valid_d = 1'b0;
    commit_pc_d    = commit_pc_q;
    break_d        = 1'b0;
    irq_no_d       = irq_no_q;
    trap_pc_d      = trap_pc_q;
    unique case (state_q)
      StIdle: begin
        if (take_trap) begin
          csr_we_d    = 1'b1;
          csr_waddr_d = MEPC_ADDR;
          csr_wdata_d = bus.pc_i;
          irq_no_d    = bus.irq_no_i;
          trap_pc_d   = bus.pc_i;
        end else if (accept) begin
          // x0 is hardwired to zero, so its write strobe is dropped.
          if (bus.Gpr_Write_i && (bus.Gpr_Write_Addr_i != 4'd0)) begin
            gpr_we_d    = 1'b1;
            gpr_waddr_d = bus.Gpr_Write_Addr_i;
            gpr_wdata_d = gpr_sel_data;
          end
          if (bus.Csr_Write_i) begin
            csr_we_d    = 1'b1;
            csr_waddr_d = bus.Csr_Write_Addr_i;
            csr_wdata_d = csr_sel_data;
          end
          commit_valid_d = 1'b1;
          commit_pc_d    = bus.pc_i;
          break_d        = bus.is_break_i;
        end
      end
      StTrapCause: begin
        csr_we_d       = 1'b1;
        csr_waddr_d    = MCAUSE_ADDR;
        csr_wdata_d    = {24'b0, irq_no_q};
        commit_valid_d = 1'b1;
        commit_pc_d    = trap_pc_q;
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      gpr_we_q       <= 1'b0;
      gpr_waddr_q    <= 4'b0;
      gpr_wdata_q    <= 32'b0;
      csr_we_q       <= 1'b0;
      csr_waddr_q    <= 12'b0;
      csr_wdata_q    <= 32'b0;
      commit_valid_q <= 1'b0;
      commit_pc_q    <= 32'b0;
      break_q        <= 1'b0;
      irq_no_q       <= 8'b0;
      trap_pc_q      <= 32'b0;
    end else begin
      gpr_we_q       <= gpr_we_d;
      gpr_waddr_q    <= gpr_waddr_d;
      gpr_wdata_q    <= gpr_wdata_d;
      csr_we_q       <= csr_we_d;
      csr_waddr_q    <= csr_waddr_d;
      csr_wdata_q    <= csr_wdata_d;
      commit_valid_q <= commit_valid_d;
      commit_pc_q    <= commit_pc_d;
      break_q        <= break_d;
      irq_no_q       <= irq_no_d;
      trap_pc_q      <= trap_pc_d;
    end
  end

  assign gpr_we       = gpr_we_q;
  assign gpr_waddr    = gpr_waddr_q;
  assign gpr_wdata    = gpr_wdata_q;
  assign csr_we       = csr_we_q;
  assign csr_waddr    = csr_waddr_q;
  assign csr_wdata    = csr_wdata_q;
  assign commit_valid = commit_valid_q;
  assign commit_pc    = commit_pc_q;
  assign break_o      = break_q;

endmodule

// File: tb/tb_ysyx_24100006_wbu.sv
// Self-checking bench for the write-back unit: directed test-plan sequences
// followed by random traffic, all checked against a schedule-based model.
module tb_ysyx_24100006_wbu;

  typedef struct {
    bit          valid;
    logic [31:0] pc, alu, imm, mem, rs1, csr;
    logic [3:0]  gaddr;
    logic [11:0] caddr;
    logic [2:0]  gsel;
    logic [1:0]  csel;
    logic [7:0]  irq_no;
    bit          irq, gw, cw, brk;
  } in_t;

  typedef struct {
    bit          gpr_we;
    logic [3:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    bit          csr_we;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    bit          commit;
    logic [31:0] commit_pc;
    bit          brk;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        gpr_we, csr_we, commit_valid, break_o;
  logic [3:0]  gpr_waddr;
  logic [11:0] csr_waddr;
  logic [31:0] gpr_wdata, csr_wdata, commit_pc;

  ysyx_24100006_wbu_if bus ();

  ysyx_24100006_wbu dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .gpr_we       (gpr_we),
    .gpr_waddr    (gpr_waddr),
    .gpr_wdata    (gpr_wdata),
    .csr_we       (csr_we),
    .csr_waddr    (csr_waddr),
    .csr_wdata    (csr_wdata),
    .commit_valid (commit_valid),
    .commit_pc    (commit_pc),
    .break_o      (break_o)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sched[$];  // expected output per upcoming cycle
  bit   halted    = 1'b0;
  bit   after_rst = 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, got, want);
  endtask

  function automatic logic [31:0] ref_gpr(input in_t x);
    case (x.gsel)
      3'd0:    return x.alu;
      3'd1:    return x.imm;
      3'd2:    return x.mem;
      3'd3:    return x.pc + 32'd4;
      3'd4:    return x.csr;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] ref_csr(input in_t x);
    case (x.csel)
      2'd0:    return x.rs1;
      2'd1:    return x.csr | x.rs1;
      2'd2:    return x.csr & ~x.rs1;
      default: return x.alu;
    endcase
  endfunction

  function automatic in_t idle_in();
    in_t x;
    x = '{default: '0};
    return x;
  endfunction

  function automatic in_t rand_in();
    in_t x;
    x.valid  = ($urandom_range(3) != 0);
    x.pc     = $urandom & 32'hFFFF_FFFC;
    x.alu    = $urandom;
    x.imm    = $urandom;
    x.mem    = $urandom;
    x.rs1    = $urandom;
    x.csr    = $urandom;
    x.gaddr  = 4'($urandom);
    x.caddr  = 12'($urandom);
    x.gsel   = 3'($urandom);
    x.csel   = 2'($urandom);
    x.irq_no = 8'($urandom);
    x.irq    = ($urandom_range(3) == 0);
    x.gw     = ($urandom_range(1) == 0);
    x.cw     = ($urandom_range(2) == 0);
    x.brk    = ($urandom_range(31) == 0);
    return x;
  endfunction

  // One cycle: check outputs from the last edge, then drive and model the next.
  task automatic step(input in_t x, input bit rst);
    exp_t e, e2;
    @(negedge clk);
    if (after_rst) begin
      after_rst = 1'b0;
      check("rst_gpr_we", 32'(gpr_we), 32'd0);
      check("rst_gpr_waddr", 32'(gpr_waddr), 32'd0);
      check("rst_gpr_wdata", gpr_wdata, 32'd0);
      check("rst_csr_we", 32'(csr_we), 32'd0);
      check("rst_csr_waddr", 32'(csr_waddr), 32'd0);
      check("rst_csr_wdata", csr_wdata, 32'd0);
      check("rst_commit", 32'(commit_valid), 32'd0);
      check("rst_commit_pc", commit_pc, 32'd0);
      check("rst_break", 32'(break_o), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    end else begin
      e = '{default: '0};
      if (sched.size() > 0) e = sched.pop_front();
      check("gpr_we", 32'(gpr_we), 32'(e.gpr_we));
      check("csr_we", 32'(csr_we), 32'(e.csr_we));
      check("commit_valid", 32'(commit_valid), 32'(e.commit));
      check("break_o", 32'(break_o), 32'(e.brk));
      if (e.gpr_we) begin
        check("gpr_waddr", 32'(gpr_waddr), 32'(e.gpr_waddr));
        check("gpr_wdata", gpr_wdata, e.gpr_wdata);
      end
      if (e.csr_we) begin
        check("csr_waddr", 32'(csr_waddr), 32'(e.csr_waddr));
        check("csr_wdata", csr_wdata, e.csr_wdata);
      end
      if (e.commit) check("commit_pc", commit_pc, e.commit_pc);
      check("in_ready", 32'(bus.in_ready), 32'(!halted && sched.size() == 0));
    end

    bus.in_valid         = x.valid;
    bus.pc_i             = x.pc;
    bus.alu_result_i     = x.alu;
    bus.sext_imm_i       = x.imm;
    bus.Mem_rdata_i      = x.mem;
    bus.rs1_data_i       = x.rs1;
    bus.rdata_csr_i      = x.csr;
    bus.Gpr_Write_Addr_i = x.gaddr;
    bus.Csr_Write_Addr_i = x.caddr;
    bus.Gpr_Write_RD_i   = x.gsel;
    bus.Csr_Write_RD_i   = x.csel;
    bus.irq_no_i         = x.irq_no;
    bus.irq_i            = x.irq;
    bus.Gpr_Write_i      = x.gw;
    bus.Csr_Write_i      = x.cw;
    bus.is_break_i       = x.brk;
    reset                = rst;

    if (rst) begin
      sched.delete();
      halted    = 1'b0;
      after_rst = 1'b1;
    end else if (x.valid && !halted && sched.size() == 0) begin
      e = '{default: '0};
      if (x.brk || !x.irq) begin
        e.gpr_we    = x.gw && (x.gaddr != 4'd0);
        e.gpr_waddr = x.gaddr;
        e.gpr_wdata = ref_gpr(x);
        e.csr_we    = x.cw;
        e.csr_waddr = x.caddr;
        e.csr_wdata = ref_csr(x);
        e.commit    = 1'b1;
        e.commit_pc = x.pc;
        e.brk       = x.brk;
        sched.push_back(e);
        if (x.brk) halted = 1'b1;
      end else begin
        e.csr_we     = 1'b1;
        e.csr_waddr  = 12'h341;
        e.csr_wdata  = x.pc;
        e2           = '{default: '0};
        e2.csr_we    = 1'b1;
        e2.csr_waddr = 12'h342;
        e2.csr_wdata = {24'd0, x.irq_no};
        e2.commit    = 1'b1;
        e2.commit_pc = x.pc;
        sched.push_back(e);
        sched.push_back(e2);
      end
    end
  endtask

  initial begin
    in_t x;
    reset = 1'b1;
    step(idle_in(), 1'b1);
    step(idle_in(), 1'b0);

    // addi x5 then lw x6, back to back
    x = idle_in(); x.valid = 1; x.pc = 32'h8000_0000; x.gw = 1; x.gaddr = 4'd5;
    x.gsel = 3'd0; x.alu = 32'h10;
    step(x, 1'b0);
    x = idle_in(); x.valid = 1; x.pc = 32'h8000_0004; x.gw = 1; x.gaddr = 4'd6;
    x.gsel = 3'd2; x.mem = 32'hDEAD_BEEF;
    step(x, 1'b0);
    // write to x0
    x = idle_in(); x.valid = 1; x.pc = 32'h8000_0008; x.gw = 1; x.gaddr = 4'd0;
    x.alu = 32'h1234;
    step(x, 1'b0);
    // csrrs rd=7, mstatus
    x = idle_in(); x.valid = 1; x.pc = 32'h8000_000C; x.gw = 1; x.gaddr = 4'd7;
    x.gsel = 3'd4; x.cw = 1; x.caddr = 12'h300; x.csel = 2'd1;
    x.rs1 = 32'h8; x.csr = 32'h1800;
    step(x, 1'b0);
    // ecall with in_valid held high on a following addi
    x = idle_in(); x.valid = 1; x.pc = 32'h8000_0100; x.irq = 1; x.irq_no = 8'd11;
    x.gw = 1; x.gaddr = 4'd3; x.cw = 1;
    step(x, 1'b0);
    x = idle_in(); x.valid = 1; x.pc = 32'h8000_0104; x.gw = 1; x.gaddr = 4'd9;
    x.alu = 32'h55;
    step(x, 1'b0);
    step(x, 1'b0);
    // jal at top of address space wraps
    x = idle_in(); x.valid = 1; x.pc = 32'hFFFF_FFFC; x.gw = 1; x.gaddr = 4'd1;
    x.gsel = 3'd3;
    step(x, 1'b0);
    // ebreak, then stay halted while valid is offered
    x = idle_in(); x.valid = 1; x.pc = 32'h8000_0200; x.brk = 1; x.irq = 1;
    x.gw = 1; x.gaddr = 4'd2; x.alu = 32'h77;
    step(x, 1'b0);
    x.brk = 0; x.irq = 0;
    for (int i = 0; i < 4; i++) step(x, 1'b0);
    step(idle_in(), 1'b1);
    // reset during the mcause cycle drops it
    x = idle_in(); x.valid = 1; x.pc = 32'h8000_0300; x.irq = 1; x.irq_no = 8'd3;
    step(x, 1'b0);
    step(idle_in(), 1'b1);
    step(idle_in(), 1'b0);
    step(idle_in(), 1'b0);

    for (int i = 0; i < 2000; i++) step(rand_in(), ($urandom_range(49) == 0));
    step(idle_in(), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_24100006_wbu.md
Name: ysyx_24100006_wbu

Overview:
Write-back unit; the consumer end of the MEM/WB pipeline register's valid/ready handshake. It accepts one retired instruction per handshake, selects the GPR and CSR write-back data, and drives registered single-cycle write pulses into the register file and CSR file. Trap entry is sequenced as two CSR writes (mepc, then mcause) by a small FSM. It emits the commit and ebreak pulses used by difftest and the simulator.

Parameters:
MEPC_ADDR, 12'h341, CSR address written with the trapping PC
MCAUSE_ADDR, 12'h342, CSR address written with the cause

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
in_valid  in  1  MEM/WB entry valid
in_ready  out  1  WBU can accept an entry this cycle
pc_i  in  32  instruction PC
alu_result_i  in  32  ALU result
sext_imm_i  in  32  sign-extended immediate
Mem_rdata_i  in  32  load data (already extended)
rs1_data_i  in  32  rs1 value
rdata_csr_i  in  32  CSR old value
Gpr_Write_Addr_i  in  4  rd (RV32E)
Csr_Write_Addr_i  in  12  CSR address
Gpr_Write_RD_i  in  3  GPR data select
Csr_Write_RD_i  in  2  CSR data select
irq_no_i  in  8  trap cause number
irq_i  in  1  trap entry request
Gpr_Write_i  in  1  GPR write enable
Csr_Write_i  in  1  CSR write enable
is_break_i  in  1  ebreak
gpr_we  out  1  GPR write strobe
gpr_waddr  out  4  GPR write address
gpr_wdata  out  32  GPR write data
csr_we  out  1  CSR write strobe
csr_waddr  out  12  CSR write address
csr_wdata  out  32  CSR write data
commit_valid  out  1  instruction retired (one-cycle pulse)
commit_pc  out  32  PC of retired instruction
break_o  out  1  ebreak retired (one-cycle pulse)

Behaviour:
- Accept = in_valid && in_ready. in_ready = (state == IDLE); combinational from state only, never from in_valid.
- FSM states: IDLE, TRAP_CAUSE, HALT. Reset -> IDLE. All outputs reset to 0.
- Every output is registered. Strobes (gpr_we, csr_we, commit_valid, break_o) default to 0 each cycle; addr/data hold their last value.
- Accept in IDLE at cycle T, irq_i=0: writes appear at T+1.
  - gpr_we = Gpr_Write_i && (Gpr_Write_Addr_i != 0); x0 writes are suppressed.
  - GPR select: 0 alu_result, 1 sext_imm, 2 Mem_rdata, 3 pc_i+4 (32-bit wrap), 4 rdata_csr; 5-7 give 0.
  - csr_we = Csr_Write_i; csr_waddr = Csr_Write_Addr_i.
  - CSR select: 0 rs1_data, 1 rdata_csr|rs1_data, 2 rdata_csr&~rs1_data, 3 alu_result.
  - GPR and CSR writes are simultaneous at T+1 (csrrw rd gets rdata_csr).
  - commit_valid=1 and commit_pc=pc_i at T+1.
  - State stays IDLE, giving 1 instruction/cycle throughput.
- Accept in IDLE with irq_i=1: Gpr_Write_i and Csr_Write_i are ignored.
  - T+1: csr_we=1, csr_waddr=MEPC_ADDR, csr_wdata=pc_i; irq_no is latched; state -> TRAP_CAUSE, so in_ready=0 at T+1.
  - T+2: csr_we=1, csr_waddr=MCAUSE_ADDR, csr_wdata={24'b0, irq_no}; commit_valid=1, commit_pc=trapping pc; state -> IDLE.
- Accept with is_break_i=1: normal writes at T+1, plus break_o=1 at T+1. State -> HALT.
  - HALT: in_ready=0 until reset; no further strobes.
- is_break_i takes priority over irq_i if both are set (treated as break; no trap writes).
- in_valid=0 in IDLE: no strobes; input data values are don't-care.
- Reset at any cycle, including mid-trap: next cycle IDLE, all strobes 0, the pending mcause write is dropped.

Decomposition:
- Shared package: GPR select encodings (ALU, IMM, MEM, PC4, CSR), CSR select encodings (RW, RS, RC, ALU), the MEPC/MCAUSE address constants, and the FSM state encoding.
- No sub-module; the data-select muxes stay inline.

Test Plan:
- Back-to-back addi x5 (sel 0, alu=0x10) then lw x6 (sel 2, rdata=0xDEADBEEF), in_valid held high -> gpr_we pulses on consecutive cycles with (5,0x10) then (6,0xDEADBEEF); in_ready stays 1; commit_pc tracks each PC.
- Write to x0 with Gpr_Write_i=1 -> gpr_we=0, commit_valid=1.
- csrrs: rs1=0x8, rdata_csr=0x1800, addr 0x300 -> same cycle: csr_we (0x300, 0x1808) and gpr_we rd=0x1800.
- ecall at pc=0x80000100, irq_no=11, in_valid held high -> T+1 mepc=0x80000100 with in_ready=0; T+2 mcause=0x0000000B with commit_valid; next entry accepted at T+2.
- jal at pc=0xFFFFFFFC, sel 3 -> gpr_wdata=0x00000000 (wrap).
- ebreak -> break_o pulse at T+1, then in_ready=0 until reset. Assert reset during TRAP_CAUSE -> no mcause write, in_ready=1 after reset.
